// File: rtl/poly_collect.sv
`default_nettype none
// ============================================================================
// Module      : poly_collect
// Description : Packs sampled coefficients into a pair-wide storage array and
//               serves registered reads once a full polynomial has been seen.
//               Optional range check: define POLY_COLLECT_RANGE_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_collect #(
    parameter  int N_COEF = 256,
    parameter  int Q      = 3329,
    localparam int AW     = (N_COEF > 2) ? $clog2(N_COEF / 2) : 1,
    localparam int CW     = $clog2(N_COEF) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [11:0]   i_first,
    input  logic [11:0]   i_second,
    input  logic          i_first_en,
    input  logic          i_second_en,
    input  logic          i_done,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [23:0]   o_rd_data,
    output logic          o_rd_valid,
    output logic [CW-1:0] o_cnt,
    output logic          o_full,
    output logic          o_err
);

    localparam logic [1:0]    S_IDLE    = 2'd0;
    localparam logic [1:0]    S_COLLECT = 2'd1;
    localparam logic [1:0]    S_FULL    = 2'd2;
    localparam logic [CW-1:0] C_N       = CW'(N_COEF);

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic [11:0]   r_pend;
    logic          r_err;
    logic [23:0]   r_rd_data;
    logic          r_rd_valid;
    logic [23:0]   r_mem [N_COEF/2];

    logic          w_first_bad;
    logic          w_second_bad;
    logic          w_first_ok;
    logic          w_second_ok;
    logic          w_active;
    logic [1:0]    w_navail;
    logic [1:0]    w_nacc;
    logic [11:0]   w_c0;
    logic          w_we;
    logic [23:0]   w_wdata;

`ifdef POLY_COLLECT_RANGE_CHK_EN
    localparam logic [31:0] C_Q = Q;
    assign w_first_bad  = i_first_en  && ({20'd0, i_first}  >= C_Q);
    assign w_second_bad = i_second_en && ({20'd0, i_second} >= C_Q);
`else
    assign w_first_bad  = 1'b0;
    assign w_second_bad = 1'b0;
`endif

    assign w_first_ok  = i_first_en  && !w_first_bad;
    assign w_second_ok = i_second_en && !w_second_bad;
    assign w_active    = (r_state == S_COLLECT) && !i_start && (r_cnt != C_N);
    assign w_navail    = {1'b0, w_first_ok} + {1'b0, w_second_ok};
    // With one slot left, the second of a pair has nowhere to go.
    assign w_nacc      = (w_navail == 2'd2 && r_cnt == C_N - 1'b1) ? 2'd1 : w_navail;
    assign w_c0        = w_first_ok ? i_first : i_second;
    assign w_we        = w_active && (r_cnt[0] ? (w_nacc != 2'd0) : (w_nacc == 2'd2));
    assign w_wdata     = r_cnt[0] ? {w_c0, r_pend} : {i_second, w_c0};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_COLLECT;
            S_COLLECT: if (i_start) w_next = S_COLLECT;
                       else if (r_cnt == C_N) w_next = S_FULL;
            S_FULL:    if (i_start) w_next = S_COLLECT;
            default:   w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_full = (r_state == S_FULL);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_pend <= '0;
            r_err  <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= '0;
            r_pend <= '0;
            r_err  <= 1'b0;
        end else if (r_state == S_COLLECT) begin
            if ((i_done && r_cnt < C_N) || (w_active && (w_first_bad || w_second_bad)))
                r_err <= 1'b1;
            if (w_active) begin
                r_cnt <= r_cnt + {{(CW-2){1'b0}}, w_nacc};
                if (!r_cnt[0] && w_nacc == 2'd1)
                    r_pend <= w_c0;
                else if (r_cnt[0] && w_nacc == 2'd2)
                    r_pend <= i_second;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_we) r_mem[r_cnt[AW:1]] <= w_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !(r_state == S_FULL && i_rd_en)) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= r_mem[i_rd_addr];
        end
    end

    assign o_cnt      = r_cnt;
    assign o_err      = r_err;
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_poly_collect.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_collect
// Description : Directed and randomized checks of poly_collect against a
//               coefficient-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_collect;

    localparam int N = 256;
    localparam int QV = 3329;
`ifdef POLY_COLLECT_RANGE_CHK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, first_en, second_en, done, rd_en;
    logic [11:0] first, second;
    logic [6:0]  rd_addr;
    logic [23:0] rd_data;
    logic        rd_valid, full, err;
    logic [8:0]  cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 idle, 1 collecting, 2 full
    int          m_mode, m_cnt;
    bit          m_err;
    logic [11:0] m_coef [N];
    bit          e_valid;
    logic [23:0] e_data;

    poly_collect #(.N_COEF(N), .Q(QV)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_first(first),
        .i_second(second), .i_first_en(first_en), .i_second_en(second_en),
        .i_done(done), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_cnt(cnt),
        .o_full(full), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rs, input bit st, input bit fe, input logic [11:0] f,
                         input bit se, input logic [11:0] s, input bit dn,
                         input bit re, input logic [6:0] ra);
        logic [11:0] vals[$];
        if (rs) begin
            m_mode = 0; m_cnt = 0; m_err = 0; e_valid = 0; e_data = '0;
            return;
        end
        if (m_mode == 2 && re) begin
            e_valid = 1;
            e_data  = {m_coef[2*int'(ra)+1], m_coef[2*int'(ra)]};
        end else begin
            e_valid = 0;
            e_data  = '0;
        end
        if (st) begin
            m_mode = 1; m_cnt = 0; m_err = 0;
        end else if (m_mode == 1) begin
            if (m_cnt == N) m_mode = 2;
            else begin
                if (dn) m_err = 1;
                if (fe) vals.push_back(f);
                if (se) vals.push_back(s);
                foreach (vals[i]) begin
                    if (RCHK && int'(vals[i]) >= QV) m_err = 1;
                    else if (m_cnt < N) begin
                        m_coef[m_cnt] = vals[i];
                        m_cnt++;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit rs, input bit st, input bit fe, input logic [11:0] f,
                        input bit se, input logic [11:0] s, input bit dn,
                        input bit re, input logic [6:0] ra);
        rst = rs; start = st; first_en = fe; first = f; second_en = se;
        second = s; done = dn; rd_en = re; rd_addr = ra;
        model(rs, st, fe, f, se, s, dn, re, ra);
        @(posedge clk);
        #1;
        chk("cnt", {23'd0, cnt}, m_cnt);
        chk("full", {31'd0, full}, {31'd0, m_mode == 2});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, e_valid});
        chk("rd_data", {8'd0, rd_data}, {8'd0, e_data});
    endtask

    task automatic idle_cyc();
        step(0, 0, 0, 12'd0, 0, 12'd0, 0, 0, 7'd0);
    endtask

    task automatic pairs(input int npairs);
        for (int k = 0; k < npairs; k++)
            step(0, 0, 1, 12'(2*k), 1, 12'(2*k+1), 0, 0, 7'd0);
    endtask

    task automatic read_all();
        for (int a = 0; a < N/2; a++)
            step(0, 0, 0, 12'd0, 0, 12'd0, 0, 1, 7'(a));
        idle_cyc();
    endtask

    initial begin
        int k;
        step(1, 0, 0, 12'd0, 0, 12'd0, 0, 0, 7'd0);
        step(1, 0, 0, 12'd0, 0, 12'd0, 0, 0, 7'd0);
        chk("reset_cnt", {23'd0, cnt}, 32'd0);
        chk("reset_full", {31'd0, full}, 32'd0);

        // Full pairs, then explicit read of address 5
        step(0, 1, 0, 12'd0, 0, 12'd0, 0, 0, 7'd0);
        pairs(128);
        idle_cyc();
        chk("pairs_full", {31'd0, full}, 32'd1);
        step(0, 0, 0, 12'd0, 0, 12'd0, 0, 1, 7'd5);
        chk("pairs_rd5", {8'd0, rd_data}, 32'h00B00A);
        chk("pairs_rd5_valid", {31'd0, rd_valid}, 32'd1);
        read_all();

        // Alternating single enables, values 1..256
        step(0, 1, 0, 12'd0, 0, 12'd0, 0, 0, 7'd0);
        for (int v = 1; v <= 256; v++) begin
            if (v % 2 == 1) step(0, 0, 1, 12'(v), 0, 12'd0, 0, 0, 7'd0);
            else            step(0, 0, 0, 12'd0, 1, 12'(v), 0, 0, 7'd0);
            chk("alt_cnt", {23'd0, cnt}, v);
        end
        idle_cyc();
        chk("alt_full", {31'd0, full}, 32'd1);
        step(0, 0, 0, 12'd0, 0, 12'd0, 0, 1, 7'd0);
        chk("alt_word0", {8'd0, rd_data}, 32'h002001);
        read_all();

        // Last slot: the second coefficient of a pair is dropped
        step(0, 1, 0, 12'd0, 0, 12'd0, 0, 0, 7'd0);
        pairs(127);
        step(0, 0, 1, 12'd77, 0, 12'd0, 0, 0, 7'd0);
        chk("edge_cnt255", {23'd0, cnt}, 32'd255);
        step(0, 0, 1, 12'd7, 1, 12'd9, 0, 0, 7'd0);
        chk("edge_cnt256", {23'd0, cnt}, 32'd256);
        chk("edge_err", {31'd0, err}, 32'd0);
        idle_cyc();
        step(0, 0, 0, 12'd0, 0, 12'd0, 0, 1, 7'd127);
        chk("edge_word127", {8'd0, rd_data}, 32'h007000 | 32'd77);

        // Early done
        step(0, 1, 0, 12'd0, 0, 12'd0, 0, 0, 7'd0);
        pairs(50);
        step(0, 0, 0, 12'd0, 0, 12'd0, 1, 0, 7'd0);
        chk("done_err", {31'd0, err}, 32'd1);
        idle_cyc();
        chk("done_stay", {31'd0, full}, 32'd0);
        step(0, 1, 0, 12'd0, 0, 12'd0, 0, 0, 7'd0);
        chk("done_clr_err", {31'd0, err}, 32'd0);
        chk("done_clr_cnt", {23'd0, cnt}, 32'd0);

        // Reset mid-collection, then read in IDLE
        pairs(30);
        chk("rst_pre", {23'd0, cnt}, 32'd60);
        step(1, 0, 1, 12'd3, 1, 12'd4, 0, 0, 7'd0);
        chk("rst_cnt", {23'd0, cnt}, 32'd0);
        step(0, 0, 1, 12'd3, 1, 12'd4, 0, 1, 7'd1);
        chk("idle_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("idle_cnt", {23'd0, cnt}, 32'd0);

        // Range check
        step(0, 1, 0, 12'd0, 0, 12'd0, 0, 0, 7'd0);
        step(0, 0, 1, 12'd3329, 1, 12'd5, 0, 0, 7'd0);
        chk("range_cnt", {23'd0, cnt}, RCHK ? 32'd1 : 32'd2);
        chk("range_err", {31'd0, err}, RCHK ? 32'd1 : 32'd0);

        // Start with data in the same cycle discards the data
        step(0, 1, 1, 12'd1, 1, 12'd2, 0, 0, 7'd0);
        chk("start_discard", {23'd0, cnt}, 32'd0);

        // Randomized polynomials with reads and a mid-read reset
        for (int p = 0; p < 3; p++) begin
            step(0, 1, 0, 12'd0, 0, 12'd0, 0, 0, 7'd0);
            k = 0;
            while (m_mode != 2 && k < 1500) begin
                step(0, ($urandom_range(0, 299) == 0), 1'($urandom), 12'($urandom_range(0, 4095)),
                     1'($urandom), 12'($urandom_range(0, 4095)), ($urandom_range(0, 49) == 0),
                     1'($urandom), 7'($urandom));
                k++;
            end
            chk("rand_reached_full", {31'd0, full}, 32'd1);
            for (int r = 0; r < 60; r++)
                step(0, 0, 1'($urandom), 12'($urandom), 1'($urandom), 12'($urandom), 0,
                     ($urandom_range(0, 3) != 0), 7'($urandom));
            step(1, 0, 0, 12'd0, 0, 12'd0, 0, 1, 7'd3);
            chk("rand_rst_valid", {31'd0, rd_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
